// File: rtl/noc_test_flit_checker.sv
// Receive-side NoC test-node checker: parses ejected flits and checks dst, framing, length and payload.
// Optional NOC_CHK_BACKPRESSURE_EN adds LFSR-driven pseudo-random backpressure on flit_ready.
module noc_test_flit_checker #(
  parameter int FLIT_W = 32,
  parameter int ID_X_W = 2,
  parameter int ID_Y_W = 2,
  parameter int X_ID   = 0,
  parameter int Y_ID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              flit_valid,
  output logic              flit_ready,
  input  logic [FLIT_W-1:0] flit_data,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  flit_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic [2:0]        last_err,
  output logic              busy
);

  // Handshake: a flit transfers on a rising edge where flit_valid and flit_ready are both high;
  // flit_data is sampled only then, and flit_ready depends on no input in the same cycle.

  localparam logic [1:0] T_HEAD   = 2'b00;
  localparam logic [1:0] T_BODY   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  localparam int DX_MSB  = FLIT_W - 3;
  localparam int DY_MSB  = DX_MSB - ID_X_W;
  localparam int SEQ_MSB = DY_MSB - ID_Y_W - ID_X_W - ID_Y_W;
  localparam int LEN_MSB = SEQ_MSB - 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BODY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  len_q, len_d;
  logic [7:0]  seq_q, seq_d;
  logic [2:0]  err_code;
  logic        pkt_done;
  logic        ready_q;
  logic        xfer;

  logic [1:0]        f_type;
  logic [ID_X_W-1:0] f_dst_x;
  logic [ID_Y_W-1:0] f_dst_y;
  logic [7:0]        f_seq;
  logic [3:0]        f_len;
  logic [FLIT_W-3:0] f_payload;
  logic [FLIT_W-3:0] exp_payload;
  logic              dst_ok;

  assign xfer        = flit_valid & ready_q;
  assign flit_ready  = ready_q;
  assign busy        = (state_q == S_BODY);
  assign f_type      = flit_data[FLIT_W-1:FLIT_W-2];
  assign f_dst_x     = flit_data[DX_MSB -: ID_X_W];
  assign f_dst_y     = flit_data[DY_MSB -: ID_Y_W];
  assign f_seq       = flit_data[SEQ_MSB -: 8];
  assign f_len       = flit_data[LEN_MSB -: 4];
  assign f_payload   = flit_data[FLIT_W-3:0];
  assign exp_payload = {{(FLIT_W-18){1'b0}}, seq_q, 4'b0000, beat_q};
  assign dst_ok      = (f_dst_x == ID_X_W'(X_ID)) && (f_dst_y == ID_Y_W'(Y_ID));

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q <= S_IDLE;
      beat_q  <= 4'd1;
      len_q   <= 4'd0;
      seq_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
    end
  end

  // One error code per flit; checks are ordered so the lowest code wins.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    len_d    = len_q;
    seq_d    = seq_q;
    err_code = 3'd0;
    pkt_done = 1'b0;
    if (xfer) begin
      if (f_type == T_HEAD || f_type == T_SINGLE) begin
        if (!dst_ok) begin
          err_code = 3'd1;
          state_d  = S_IDLE;
        end else begin
          // A start flit mid-packet abandons the old packet, then starts afresh.
          if (state_q == S_BODY) err_code = 3'd3;
          if (f_type == T_HEAD) begin
            if (f_len == 4'd0) begin
              if (err_code == 3'd0) err_code = 3'd5;
              state_d = S_IDLE;
            end else begin
              state_d = S_BODY;
              beat_d  = 4'd1;
              len_d   = f_len;
              seq_d   = f_seq;
            end
          end else begin
            state_d = S_IDLE;
            if (f_len != 4'd0) begin
              if (err_code == 3'd0) err_code = 3'd5;
            end else begin
              pkt_done = 1'b1;
            end
          end
        end
      end else if (state_q == S_IDLE) begin
        err_code = 3'd2;
      end else if (f_payload != exp_payload) begin
        err_code = 3'd4;
        state_d  = S_IDLE;
      end else if (f_type == T_TAIL) begin
        state_d = S_IDLE;
        if (beat_q == len_q) pkt_done = 1'b1;
        else                 err_code = 3'd5;
      end else begin
        if (beat_q == len_q) begin
          err_code = 3'd5;
          state_d  = S_IDLE;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      last_err <= 3'd0;
    end else if (clr_stats) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      last_err <= 3'd0;
    end else begin
      if (xfer)     flit_cnt <= sat_inc(flit_cnt);
      if (pkt_done) pkt_cnt  <= sat_inc(pkt_cnt);
      if (err_code != 3'd0) begin
        err_cnt  <= sat_inc(err_cnt);
        err_flag <= 1'b1;
        last_err <= err_code;
      end
    end
  end

`ifdef NOC_CHK_BACKPRESSURE_EN
  localparam logic [7:0] SEED_RAW = 8'(8'hA5 + X_ID + Y_ID);
  localparam logic [7:0] SEED     = (SEED_RAW == 8'd0) ? 8'h01 : SEED_RAW;

  logic [7:0] lfsr_q;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; ready is high when the low two bits are nonzero.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      lfsr_q  <= SEED;
      ready_q <= 1'b0;
    end else begin
      lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      ready_q <= (lfsr_q[1:0] != 2'b00);
    end
  end
`else
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) ready_q <= 1'b1;
    else         ready_q <= 1'b1;
  end
`endif

endmodule
